// File: rtl/sec_lock_pkg.sv
// Shared types and helpers for the key-locked single-error-correcting pipeline.
package sec_lock_pkg;

    // Key FSM states.
    typedef enum logic [1:0] {
        ST_LOCKED = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOAD   = 2'd2,
        ST_ARMED  = 2'd3
    } key_state_t;

    // out_err encodings.
    localparam logic [1:0] ERR_CLEAN  = 2'b00;  // syndrome zero
    localparam logic [1:0] ERR_DATA   = 2'b01;  // one data bit corrected
    localparam logic [1:0] ERR_CHK    = 2'b10;  // single check-bit error
    localparam logic [1:0] ERR_UNCORR = 2'b11;  // not correctable

    // Column code of data bit idx: the idx-th smallest chk_w-bit value with
    // at least two bits set. Weight >= 2 keeps data columns disjoint from the
    // weight-1 syndromes that flag a check-bit error.
    function automatic int unsigned col(input int unsigned idx, input int unsigned chk_w);
        int unsigned seen;
        int unsigned ones;
        int unsigned result;
        bit          found;
        seen   = 0;
        result = 0;
        found  = 1'b0;
        for (int unsigned v = 0; v < (32'd1 << chk_w); v++) begin
            ones = 0;
            for (int unsigned b = 0; b < chk_w; b++) begin
                ones = ones + ((v >> b) & 32'd1);
            end
            if (!found && ones >= 2) begin
                if (seen == idx) begin
                    result = v;
                    found  = 1'b1;
                end
                seen = seen + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sec_syndrome.sv
// Combinational syndrome generation and single-error correction.
// The encode side turns a (locked) data word plus received check bits into a
// syndrome; the correct side turns a registered word/syndrome pair into the
// corrected word and its error class.
module sec_syndrome
    import sec_lock_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CHK_W  = 8
) (
    input  logic [DATA_W-1:0] enc_data,
    input  logic [CHK_W-1:0]  enc_chk,
    input  logic              enc_chk_en,
    output logic [CHK_W-1:0]  enc_syn,
    input  logic [DATA_W-1:0] fix_data,
    input  logic [CHK_W-1:0]  fix_syn,
    output logic [DATA_W-1:0] fix_out,
    output logic [1:0]        fix_err
);

    logic [CHK_W-1:0] col_tab [DATA_W];

    // Column codes are elaboration-time constants.
    for (genvar i = 0; i < DATA_W; i++) begin : g_col
        localparam logic [CHK_W-1:0] CODE = CHK_W'(col(i, CHK_W));
        assign col_tab[i] = CODE;
    end

    // Syndrome: gated check bits XOR the columns of every set data bit.
    always_comb begin
        enc_syn = enc_chk & {CHK_W{enc_chk_en}};
        for (int i = 0; i < DATA_W; i++) begin
            if (enc_data[i]) enc_syn = enc_syn ^ col_tab[i];
        end
    end

    // Classify the syndrome and flip the matching data bit if there is one.
    always_comb begin
        fix_out = fix_data;
        fix_err = ERR_UNCORR;
        if (fix_syn == '0) begin
            fix_err = ERR_CLEAN;
        end else if ($countones(fix_syn) == 1) begin
            fix_err = ERR_CHK;
        end else begin
            for (int k = 0; k < DATA_W; k++) begin
                if (fix_syn == col_tab[k]) begin
                    fix_out[k] = ~fix_data[k];
                    fix_err    = ERR_DATA;
                end
            end
        end
    end

endmodule

// File: rtl/sec_lock_pipe.sv
// Key-locked two-stage SEC pipeline. A serially loaded key produces a mask
// that is folded into the data before syndrome generation; only the right
// key (key_reg == KEY_INV) gives a zero mask. Requires
// DATA_W <= 2**CHK_W - CHK_W - 1 and 1 <= KEY_W <= DATA_W.
// Handshake: a word moves on a rising edge where its valid and ready are
// both high; stage 2 loads when empty or out_ready, stage 1 advances when
// stage 2 loads, and inputs are taken only in ARMED with no key_load pending.
module sec_lock_pipe
    import sec_lock_pkg::*;
#(
    parameter int               DATA_W  = 32,
    parameter int               CHK_W   = 8,
    parameter int               KEY_W   = 11,
    parameter logic [KEY_W-1:0] KEY_INV = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_load,
    input  logic              key_bit,
    output logic              key_armed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CHK_W-1:0]  in_chk,
    input  logic              chk_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_err
);

    localparam int               CNT_W    = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W - 1);

    key_state_t        state;
    key_state_t        state_nxt;
    logic [KEY_W-1:0]  key_reg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [KEY_W-1:0]  mask;
    logic [DATA_W-1:0] locked;
    logic [CHK_W-1:0]  syn;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [CHK_W-1:0]  s1_syn;
    logic [DATA_W-1:0] fix_out;
    logic [1:0]        fix_err;
    logic              drain_req;
    logic              s1_open;
    logic              s2_open;
    logic              accept;

    assign key_armed = (state == ST_ARMED);

    // Key FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_LOCKED;
        else        state <= state_nxt;
    end

    // Key FSM next state; key_load only matters in LOCKED and ARMED.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOCKED: if (key_load) state_nxt = ST_LOAD;
            ST_ARMED:  if (key_load) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (!s1_valid && !out_valid) state_nxt = ST_LOAD;
            ST_LOAD:   if (bit_cnt == LAST_BIT) state_nxt = ST_ARMED;
            default:   state_nxt = ST_LOCKED;
        endcase
    end

    // Shift the key in MSB-first, one bit per LOAD cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg <= '0;
            bit_cnt <= '0;
        end else if (state == ST_LOAD) begin
            key_reg <= KEY_W'({key_reg, key_bit});
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    // Handshake: a key_load in ARMED blocks the input in the same cycle.
    always_comb begin
        drain_req = (state == ST_ARMED) && key_load;
        s2_open   = !out_valid || out_ready;
        s1_open   = !s1_valid || s2_open;
        in_ready  = (state == ST_ARMED) && !drain_req && s1_open;
        accept    = in_valid && in_ready;
    end

    // Fold the key mask into evenly spread data bit positions.
    always_comb begin
        mask   = key_reg ^ KEY_INV;
        locked = in_data;
        for (int j = 0; j < KEY_W; j++) begin
            locked[(j * DATA_W) / KEY_W] = locked[(j * DATA_W) / KEY_W] ^ mask[j];
        end
    end

    sec_syndrome #(
        .DATA_W (DATA_W),
        .CHK_W  (CHK_W)
    ) u_syndrome (
        .enc_data   (locked),
        .enc_chk    (in_chk),
        .enc_chk_en (chk_en),
        .enc_syn    (syn),
        .fix_data   (s1_data),
        .fix_syn    (s1_syn),
        .fix_out    (fix_out),
        .fix_err    (fix_err)
    );

    // Stage 1 holds locked data and syndrome; stage 2 holds the corrected result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_syn    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= ERR_CLEAN;
        end else begin
            if (s1_open) s1_valid <= accept;
            if (accept) begin
                s1_data <= locked;
                s1_syn  <= syn;
            end
            if (s2_open) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= fix_out;
                    out_err  <= fix_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_sec_lock_pipe.sv
// Bench for sec_lock_pipe: directed key/correction cases, streaming with
// back-pressure, drain-on-reload and reset cases, all scored against a
// word-level reference model.
module tb_sec_lock_pipe;
    import sec_lock_pkg::*;

    localparam int            DW = 32;
    localparam int            CW = 8;
    localparam int            KW = 11;
    localparam logic [KW-1:0] KEY_INV_TB = 11'h5A3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_load = 1'b0;
    logic          key_bit = 1'b0;
    logic          in_valid = 1'b0;
    logic          chk_en = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_chk = '0;
    logic          key_armed;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_err;

    int            tests = 0;
    int            fails = 0;
    int            n_acc = 0;
    int            n_out = 0;
    logic [DW+1:0] exp_q[$];
    logic [CW-1:0] code_tab[$];
    logic [KW-1:0] cur_key = '0;

    sec_lock_pipe #(
        .DATA_W  (DW),
        .CHK_W   (CW),
        .KEY_W   (KW),
        .KEY_INV (KEY_INV_TB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_load  (key_load),
        .key_bit   (key_bit),
        .key_armed (key_armed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_chk    (in_chk),
        .chk_en    (chk_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Check bits that make a word's syndrome zero under the right key.
    function automatic logic [CW-1:0] enc(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < DW; i++) if (d[i]) c = c ^ code_tab[i];
        return c;
    endfunction

    // Reference: {out_err, out_data} for one accepted word.
    function automatic logic [DW+1:0] model(input logic [DW-1:0] din, input logic [CW-1:0] chk,
                                            input logic en, input logic [KW-1:0] key);
        logic [KW-1:0] m;
        logic [DW-1:0] d;
        logic [CW-1:0] s;
        int            hit;
        m = key ^ KEY_INV_TB;
        d = din;
        for (int j = 0; j < KW; j++) if (m[j]) d = d ^ (DW'(1) << ((j * DW) / KW));
        s = en ? chk : '0;
        for (int i = 0; i < DW; i++) if (d[i]) s = s ^ code_tab[i];
        if (s == '0) return {2'b00, d};
        hit = -1;
        for (int i = 0; i < DW; i++) if (code_tab[i] == s) hit = i;
        if (hit >= 0) return {2'b01, d ^ (DW'(1) << hit)};
        if ($countones(s) == 1) return {2'b10, d};
        return {2'b11, d};
    endfunction

    // scoreboard: check the head on every valid cycle (covers stall stability),
    // pop on transfer, then enqueue the word accepted this cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'(0));
                end else begin
                    check("out_data", 64'(out_data), 64'(exp_q[0][DW-1:0]));
                    check("out_err", 64'(out_err), 64'(exp_q[0][DW+1:DW]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data, in_chk, chk_en, cur_key));
                n_acc++;
            end
        end
    end

    // driver tasks: all start and end #1 after a rising edge
    task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic en,
                        output int waited);
        bit ok;
        ok     = 1'b0;
        waited = 0;
        in_data = d; in_chk = c; chk_en = en; in_valid = 1'b1;
        while (!ok && waited < 200) begin
            @(negedge clk);
            ok = in_ready;
            waited++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("accept", 64'(ok), 64'(1));
    endtask

    task automatic send_expect(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic en,
                               input logic [DW-1:0] exp_d, input logic [1:0] exp_e, input string tag);
        int w;
        send(d, c, en, w);
        @(negedge clk);
        check({tag, "_lat1"}, 64'(out_valid), 64'(0));
        @(negedge clk);
        check({tag, "_lat2"}, 64'(out_valid), 64'(1));
        check({tag, "_data"}, 64'(out_data), 64'(exp_d));
        check({tag, "_err"}, 64'(out_err), 64'(exp_e));
        @(posedge clk); #1;
    endtask

    task automatic rand_word(output logic [DW-1:0] d, output logic [CW-1:0] c, output logic en);
        d = DW'($urandom);
        c = enc(d);
        en = 1'b1;
        case ($urandom_range(0, 4))
            1: d = d ^ (DW'(1) << $urandom_range(0, DW - 1));
            2: c = c ^ (CW'(1) << $urandom_range(0, CW - 1));
            3: c = CW'($urandom);
            4: en = 1'b0;
            default: ;
        endcase
    endtask

    // Load a key; rst_at >= 0 asserts reset while that bit index is driven.
    task automatic load_key(input logic [KW-1:0] k, input int rst_at);
        int guard;
        guard = 0;
        key_load = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("keyload_blocks_in", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        key_load = 1'b0;
        in_valid = 1'b0;
        while (dut.state != ST_LOAD && guard < 100) begin
            @(negedge clk);
            check("drain_in_ready", 64'(in_ready), 64'(0));
            @(posedge clk); #1;
            guard++;
        end
        check("load_started", 64'(dut.state == ST_LOAD), 64'(1));
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        cur_key = k;
        for (int b = KW - 1; b >= 0; b--) begin
            key_bit = k[b];
            if (KW - 1 - b == rst_at) begin
                #2 rst_n = 1'b0;
                exp_q.delete();
                return;
            end
            @(negedge clk);
            check("load_in_ready", 64'(in_ready), 64'(0));
            check("load_armed", 64'(key_armed), 64'(0));
            @(posedge clk); #1;
        end
        key_bit = 1'b0;
        @(negedge clk);
        check("armed_after_load", 64'(key_armed), 64'(1));
        check("ready_after_load", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_data"}, 64'(out_data), 64'(0));
        check({tag, "_err"}, 64'(out_err), 64'(0));
        check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        check({tag, "_armed"}, 64'(key_armed), 64'(0));
        check({tag, "_state"}, 64'(dut.state == ST_LOCKED), 64'(1));
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          en;
        int            w;
        int            acc;
        int            acc0;
        int            out0;

        for (int v = 1; code_tab.size() < DW; v++) begin
            if ($countones(v) >= 2) code_tab.push_back(CW'(v));
        end

        // reset
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("locked_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;

        // right key, clean zero word, two-cycle latency
        load_key(11'h5A3, -1);
        send_expect('0, enc('0), 1'b1, '0, ERR_CLEAN, "zero");

        // single data error, check-bit error, double data error (bits 5, 26)
        d = DW'($urandom);
        send_expect(d ^ 32'h0000_0020, enc(d), 1'b1, d, ERR_DATA, "bit5");
        send_expect(d, enc(d) ^ 8'h08, 1'b1, d, ERR_CHK, "chk3");
        send_expect(d ^ 32'h0400_0020, enc(d), 1'b1, d ^ 32'h0400_0020, ERR_UNCORR, "two_bits");

        // wrong key: bit-0 mask is seen as a data error, and combined with a
        // real error on bit 5 it mis-corrects bit 4
        load_key(11'h5A2, -1);
        send_expect('0, '0, 1'b1, '0, ERR_DATA, "wrong_key_zero");
        send_expect(32'h0000_0020, '0, 1'b1, 32'h0000_0031, ERR_DATA, "wrong_key_mis");
        load_key(11'h5A3, -1);

        // one word per cycle with out_ready high
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            rand_word(d, c, en);
            send(d, c, en, w);
            acc += w;
        end
        check("throughput", 64'(acc), 64'(6));
        repeat (4) @(posedge clk);
        #1;

        // 8 words with out_ready pattern 1,0,0,1
        acc0 = n_acc;
        out0 = n_out;
        fork
            for (int i = 0; i < 8; i++) begin
                logic [DW-1:0] sd;
                logic [CW-1:0] sc;
                logic          se;
                int            sw;
                rand_word(sd, sc, se);
                send(sd, sc, se, sw);
            end
            for (int cy = 0; cy < 40; cy++) begin
                out_ready = (cy % 4 == 0) || (cy % 4 == 3);
                @(posedge clk); #1;
            end
        join
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("stream_accepted", 64'(n_acc - acc0), 64'(8));
        check("stream_delivered", 64'(n_out - out0), 64'(8));
        check("stream_empty", 64'(exp_q.size()), 64'(0));

        // key reload with two words in flight
        out_ready = 1'b0;
        out0 = n_out;
        rand_word(d, c, en);
        send(d, c, en, w);
        rand_word(d, c, en);
        send(d, c, en, w);
        check("inflight_two", 64'(exp_q.size()), 64'(2));
        fork
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            load_key(11'h5A3, -1);
        join
        check("inflight_delivered", 64'(n_out - out0), 64'(2));
        send_expect(32'h1234_5678, enc(32'h1234_5678), 1'b1, 32'h1234_5678, ERR_CLEAN, "after_reload");

        // reset with words in flight: nothing comes out afterwards
        out_ready = 1'b0;
        send(32'hDEAD_BEEF, enc(32'hDEAD_BEEF), 1'b1, w);
        send(32'hCAFE_F00D, enc(32'hCAFE_F00D), 1'b1, w);
        #2 rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("rst_inflight");
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_out_after_rst", 64'(out_valid), 64'(0));
        end
        @(posedge clk); #1;

        // reset during the 6th key bit
        load_key(11'h5A3, 5);
        @(negedge clk);
        check_reset_outputs("rst_mid_load");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("locked_after_rst", 64'(dut.state == ST_LOCKED), 64'(1));
        @(posedge clk); #1;

        // random traffic with random back-pressure
        load_key(11'h5A3, -1);
        acc0 = n_acc;
        out0 = n_out;
        fork
            for (int i = 0; i < 30; i++) begin
                logic [DW-1:0] rd;
                logic [CW-1:0] rc;
                logic          re;
                int            rw;
                rand_word(rd, rc, re);
                send(rd, rc, re, rw);
            end
            for (int cy = 0; cy < 200; cy++) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        join
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("random_delivered", 64'(n_out - out0), 64'(n_acc - acc0));
        check("random_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
